instr_issue_queue: RTL
======================

Name: instr_issue_queue

Overview:
- Producer side of the instruction interface into the control coordinator (instr / instr_enable / busy / synchronize).
- Buffers host-pushed instructions in a FIFO and presents them one at a time to the coordinator, honouring its busy back-pressure.
- Stops issuing after a synchronise instruction (opcode 8'hFF) until the coordinator reports completion via synchronize.
- Sits between the host/instruction-fetch front end and the control coordinator.

Parameters:
INSTR_WIDTH, 80, flat instruction width; opcode = bits [INSTR_WIDTH-1 -: 8].
DEPTH, 16, FIFO entries; power of 2, >= 2.
CNT_WIDTH, 16, width of the issued-instruction and completed-sync counters.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset, asynchronous, active-high.
push_valid  in  1  host offers an instruction.
push_instr  in  INSTR_WIDTH  instruction offered by the host.
push_ready  out  1  FIFO can accept; equals !full.
run  in  1  issue enable; 0 pauses issuing without affecting push.
instr  out  INSTR_WIDTH  instruction presented to the coordinator.
instr_enable  out  1  instr is valid.
coord_enable  out  1  enable to the coordinator; equals run.
busy  in  1  coordinator busy; it loads instr only when busy=0 and enable=1.
synchronize  in  1  one-cycle pulse from the coordinator when a sync instruction completes.
sync_done  out  1  registered one-cycle pulse, one cycle after synchronize is seen in WAIT_SYNC.
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
issued_count  out  CNT_WIDTH  instructions accepted by the coordinator; wraps modulo 2^CNT_WIDTH.
sync_count  out  CNT_WIDTH  completed syncs; wraps modulo 2^CNT_WIDTH.
idle  out  1  FIFO empty AND state ISSUE AND busy=0.

Behaviour:
- Reset (asynchronous, any time, including mid-sync):
  - FIFO pointers and fifo_count cleared; counters = 0; state = ISSUE.
  - instr = 0, instr_enable = 0, sync_done = 0, push_ready = 1.
- FIFO:
  - Push occurs on an edge with push_valid && push_ready.
  - First-word-fall-through: a push into an empty FIFO is visible at the head on the next cycle (latency 1). There is no same-cycle bypass.
  - When full, push_ready = 0, including in a cycle where a pop also occurs.
  - Simultaneous push and pop while not full or empty: fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- Issue handshake (combinational outputs from the FIFO head):
  - instr = head entry.
  - instr_enable = (state == ISSUE) && !empty && run.
  - Accept = instr_enable && !busy && coord_enable. On an accept edge: pop the head and increment issued_count.
  - While busy = 1, instr and instr_enable must stay stable.
  - When not enabled, instr holds the head value (0 if empty); it is never X.
- State machine:
  - ISSUE -> WAIT_SYNC when the accepted instruction has opcode 8'hFF.
  - WAIT_SYNC: instr_enable = 0; the FIFO continues to accept pushes.
  - WAIT_SYNC -> ISSUE on synchronize = 1. That edge also increments sync_count and sets sync_done = 1 for exactly the next cycle.
  - The first post-sync instruction may be presented in the cycle after synchronize.
- Other rules:
  - synchronize in state ISSUE is ignored: no count, no pulse.
  - run = 0 in WAIT_SYNC does not block sync completion.
  - Opcode 8'h00 (NOP) is issued like any other instruction; no filtering.

Test Plan:
- Reset, push 3 non-sync instructions (opcodes 8'h08, 8'h20, 8'h80), run=1, busy=0:
  - Three consecutive accept cycles starting 1 cycle after the first push.
  - issued_count = 3, fifo_count = 0, idle = 1.
- Head opcode 8'h20 with busy held 1 for 5 cycles:
  - instr and instr_enable stable for all 5 cycles, fifo_count unchanged.
  - Pop on the first busy=0 edge.
- Push sync (8'hFF) followed by 8'h08:
  - After the sync is accepted, instr_enable = 0 until synchronize is pulsed 10 cycles later.
  - sync_done is high for 1 cycle; sync_count = 1.
  - 8'h08 is presented the following cycle.
- Push DEPTH+1 instructions with run=0:
  - push_ready drops after 16 pushes; fifo_count = 16; the 17th push waits.
  - Set run=1: push_ready returns after the first pop.
- Assert rst for 1 cycle in WAIT_SYNC with 4 entries queued:
  - Immediately: fifo_count = 0, counters = 0, instr_enable = 0, state ISSUE.
  - A later synchronize pulse produces no sync_done.
- Pulse synchronize in state ISSUE with the FIFO empty:
  - sync_count stays 0, sync_done stays 0.

Source files
------------

// File: rtl/instr_issue_queue.sv
// ============================================================================
// Module      : instr_issue_queue
// Description : FWFT instruction FIFO feeding the control coordinator; stalls
//               issue after a sync opcode until the coordinator signals done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_issue_queue #(
  parameter int INSTR_WIDTH = 80,
  parameter int DEPTH       = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [INSTR_WIDTH-1:0]   push_instr,
  output logic                     push_ready,
  input  logic                     run,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic                     instr_enable,
  output logic                     coord_enable,
  input  logic                     busy,
  input  logic                     synchronize,
  output logic                     sync_done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]     issued_count,
  output logic [CNT_WIDTH-1:0]     sync_count,
  output logic                     idle
);

  localparam int                c_ADDR_W  = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0] c_FULL    = (c_ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]        c_SYNC_OP = 8'hFF;

  typedef enum logic [0:0] {
    ST_ISSUE     = 1'b0,
    ST_WAIT_SYNC = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [INSTR_WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ADDR_W-1:0]      r_wr_ptr;
  logic [c_ADDR_W-1:0]      r_rd_ptr;
  logic [c_ADDR_W:0]        r_count;
  logic [CNT_WIDTH-1:0]     r_issued;
  logic [CNT_WIDTH-1:0]     r_syncs;
  logic                     r_sync_done;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_sync_hit;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_FULL);
  assign w_push       = push_valid && !w_full;

  // Head is forced to zero when empty so the coordinator never sees stale or X data.
  assign instr        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign instr_enable = (r_state == ST_ISSUE) && !w_empty && run;
  assign coord_enable = run;
  assign w_pop        = instr_enable && !busy && coord_enable;
  assign w_sync_hit   = (r_state == ST_WAIT_SYNC) && synchronize;

  assign push_ready   = !w_full;
  assign fifo_count   = r_count;
  assign issued_count = r_issued;
  assign sync_count   = r_syncs;
  assign sync_done    = r_sync_done;
  assign idle         = w_empty && (r_state == ST_ISSUE) && !busy;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ISSUE: begin
        if (w_pop && (instr[INSTR_WIDTH-1 -: 8] == c_SYNC_OP)) begin
          w_state_next = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (synchronize) begin
          w_state_next = ST_ISSUE;
        end
      end
      default: w_state_next = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ISSUE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_syncs     <= '0;
      r_sync_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sync_done <= w_sync_hit;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      if (w_sync_hit) begin
        r_syncs <= r_syncs + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; unoccupied entries are never presented.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_instr;
    end
  end

endmodule

`default_nettype wire
